// File: rtl/hazard_pkg.sv
// Shared types and output patterns for the pipeline hazard controller.
// Optional performance counters are enabled with HAZARD_PERF_EN.
package hazard_pkg;

    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } state_t;

    localparam int REG_ZERO = 0;

    // Output patterns are packed as {PCWrite, IFIDWrite, IFFlush, EXFlush}
    localparam logic [3:0] PAT_STALL = 4'b0001;
    localparam logic [3:0] PAT_IDLE  = 4'b1100;
    localparam logic [3:0] PAT_FLUSH = 4'b1110;

endpackage

// File: rtl/hazard_if.sv
// Pipeline-side bundle for the hazard controller: ID/EX/MEM fields in, stall/flush controls out.
// The StallCycles/FlushCount counters exist only when HAZARD_PERF_EN is defined.
interface hazard_if #(
    parameter int REG_W  = 5,
    parameter int PERF_W = 32
);
    logic [REG_W-1:0] ID_Rs;
    logic [REG_W-1:0] ID_Rt;
    logic             ID_UsesRt;
    logic             ID_Branch;
    logic             ID_Taken;
    logic             IDEX_MemRead;
    logic             IDEX_RegWrite;
    logic [REG_W-1:0] IDEX_WriteReg;
    logic             EXMEM_MemRead;
    logic [REG_W-1:0] EXMEM_WriteReg;
    logic             PCWrite;
    logic             IFIDWrite;
    logic             IFFlush;
    logic             EXFlush;
    logic             Stalled;
`ifdef HAZARD_PERF_EN
    logic [PERF_W-1:0] StallCycles;
    logic [PERF_W-1:0] FlushCount;
`endif

    // The pipeline drives instruction fields; the controller answers with controls
    modport master (
        output ID_Rs, ID_Rt, ID_UsesRt, ID_Branch, ID_Taken,
        output IDEX_MemRead, IDEX_RegWrite, IDEX_WriteReg,
        output EXMEM_MemRead, EXMEM_WriteReg,
`ifdef HAZARD_PERF_EN
        input  StallCycles, FlushCount,
`endif
        input  PCWrite, IFIDWrite, IFFlush, EXFlush, Stalled
    );

    modport slave (
        input  ID_Rs, ID_Rt, ID_UsesRt, ID_Branch, ID_Taken,
        input  IDEX_MemRead, IDEX_RegWrite, IDEX_WriteReg,
        input  EXMEM_MemRead, EXMEM_WriteReg,
`ifdef HAZARD_PERF_EN
        output StallCycles, FlushCount,
`endif
        output PCWrite, IFIDWrite, IFFlush, EXFlush, Stalled
    );
endinterface

// File: rtl/hazard_match.sv
// Combinational source-operand comparator: does a pipeline destination feed the ID instruction?
// Register zero is hardwired and never produces a match.
module hazard_match
    import hazard_pkg::*;
#(
    parameter int REG_W = 5
) (
    input  logic [REG_W-1:0] dest,
    input  logic [REG_W-1:0] rs,
    input  logic [REG_W-1:0] rt,
    input  logic             uses_rt,
    output logic             match
);

    assign match = (dest != REG_W'(REG_ZERO)) &&
                   ((dest == rs) || (uses_rt && (dest == rt)));

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use and branch-in-ID stalls, taken-branch IF flush.
// Define HAZARD_PERF_EN to add saturating StallCycles/FlushCount counters.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_W  = 5,
    parameter int CNT_W  = 2,
    parameter int PERF_W = 32
) (
    input  logic   Clk,
    input  logic   Rst,
    hazard_if.slave hif
);

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic [3:0]       pat;
    logic             ex_match;
    logic             mem_match;

    hazard_match #(.REG_W(REG_W)) u_match_ex (
        .dest    (hif.IDEX_WriteReg),
        .rs      (hif.ID_Rs),
        .rt      (hif.ID_Rt),
        .uses_rt (hif.ID_UsesRt),
        .match   (ex_match)
    );

    hazard_match #(.REG_W(REG_W)) u_match_mem (
        .dest    (hif.EXMEM_WriteReg),
        .rs      (hif.ID_Rs),
        .rt      (hif.ID_Rt),
        .uses_rt (hif.ID_UsesRt),
        .match   (mem_match)
    );

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // A branch waiting on a load in EX needs a second bubble, which STALL supplies
    // without looking at the inputs; the flush only goes out once operands are clean.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        pat        = PAT_IDLE;
        if (!Rst) begin
            case (state)
                RUN: begin
                    if (hif.ID_Branch && hif.IDEX_MemRead && ex_match) begin
                        pat        = PAT_STALL;
                        state_next = STALL;
                        cnt_next   = CNT_W'(1);
                    end else if (hif.ID_Branch && hif.IDEX_RegWrite && ex_match) begin
                        pat = PAT_STALL;
                    end else if (hif.ID_Branch && hif.EXMEM_MemRead && mem_match) begin
                        pat = PAT_STALL;
                    end else if (!hif.ID_Branch && hif.IDEX_MemRead && ex_match) begin
                        pat = PAT_STALL;
                    end else if (hif.ID_Branch && hif.ID_Taken) begin
                        pat = PAT_FLUSH;
                    end
                end
                STALL: begin
                    pat      = PAT_STALL;
                    cnt_next = cnt - CNT_W'(1);
                    if (cnt <= CNT_W'(1)) begin
                        state_next = RUN;
                    end
                end
                default: begin
                    state_next = RUN;
                    cnt_next   = '0;
                end
            endcase
        end
    end

    assign hif.PCWrite   = pat[3];
    assign hif.IFIDWrite = pat[2];
    assign hif.IFFlush   = pat[1];
    assign hif.EXFlush   = pat[0];
    assign hif.Stalled   = (state == STALL) && !Rst;

`ifdef HAZARD_PERF_EN
    logic [PERF_W-1:0] stall_cycles;
    logic [PERF_W-1:0] flush_count;

    // EXFlush is asserted only by the stall pattern, so it marks a stall cycle
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if (pat[0] && (stall_cycles != '1)) begin
                stall_cycles <= stall_cycles + PERF_W'(1);
            end
            if (pat[1] && (flush_count != '1)) begin
                flush_count <= flush_count + PERF_W'(1);
            end
        end
    end

    assign hif.StallCycles = stall_cycles;
    assign hif.FlushCount  = flush_count;
`endif

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard controller. It is the producer of the stall and flush controls consumed by the IF/ID and ID/EX pipeline registers.
- It compares the source registers of the instruction in ID against the destinations held in ID/EX and EX/MEM.
- It drives PC hold, IF/ID hold, IF/ID flush and EXFlush. EXFlush inserts a bubble into the ID/EX register.
- A small FSM with a down-counter covers multi-cycle stalls needed by branches resolved in ID.

Parameters:
- REG_W, 5, register-address width.
- CNT_W, 2, stall down-counter width; must hold the value 1 at minimum.
- PERF_W, 32, width of the performance counters (used only when the optional feature is compiled in).

Ports:
- Clk  in  1  rising-edge clock
- Rst  in  1  asynchronous reset, active-high
- ID_Rs  in  REG_W  rs field of the instruction in ID
- ID_Rt  in  REG_W  rt field of the instruction in ID
- ID_UsesRt  in  1  the ID instruction reads rt
- ID_Branch  in  1  the ID instruction compares operands in ID (beq/bne/jr)
- ID_Taken  in  1  branch/jump in ID resolves taken (only meaningful when operands are hazard-free)
- IDEX_MemRead  in  1  the instruction in EX is a load
- IDEX_RegWrite  in  1  the instruction in EX writes a register
- IDEX_WriteReg  in  REG_W  destination of the EX instruction, after the RegDst mux
- EXMEM_MemRead  in  1  the instruction in MEM is a load
- EXMEM_WriteReg  in  REG_W  destination of the MEM instruction
- PCWrite  out  1  1 = PC updates; 0 = PC holds
- IFIDWrite  out  1  1 = IF/ID loads; 0 = IF/ID holds
- IFFlush  out  1  zero the IF/ID register
- EXFlush  out  1  bubble into ID/EX (drives its EXFlush input)
- Stalled  out  1  FSM is in STALL

Behaviour:
- Match rule: srcmatch(r) = (r != 0) && (r == ID_Rs || (ID_UsesRt && r == ID_Rt)). Register 0 never causes a hazard.
- Outputs are combinational from state and inputs, and act in the same cycle.
  - Stall pattern: PCWrite=0, IFIDWrite=0, EXFlush=1, IFFlush=0.
  - Idle pattern: PCWrite=1, IFIDWrite=1, EXFlush=0, IFFlush=0.
- Reset (asynchronous, mid-operation included): state=RUN, counter=0, perf counters=0. Outputs take the idle pattern immediately.
- State RUN, evaluated in priority order:
  1. ID_Branch && IDEX_MemRead && srcmatch(IDEX_WriteReg): stall pattern this cycle; next state STALL with cnt=1. Total 2 bubbles.
  2. ID_Branch && IDEX_RegWrite && srcmatch(IDEX_WriteReg): stall pattern; stay in RUN. 1 bubble.
  3. ID_Branch && EXMEM_MemRead && srcmatch(EXMEM_WriteReg): stall pattern; stay in RUN. 1 bubble.
  4. !ID_Branch && IDEX_MemRead && srcmatch(IDEX_WriteReg) (load-use): stall pattern; stay in RUN. 1 bubble.
  5. ID_Branch && ID_Taken, with no hazard above: idle pattern except IFFlush=1 for one cycle.
  6. Otherwise: idle pattern.
- State STALL:
  - Stall pattern is forced regardless of inputs. IFFlush=0, Stalled=1.
  - cnt decrements each cycle; when cnt==0, next state is RUN.
  - The held ID instruction is re-evaluated in RUN on the following cycle. Any residual hazard is handled by the RUN rules.
- IFFlush and the stall pattern are never asserted together. A stall always takes priority, and the flush is deferred until the branch resolves.
- IFIDWrite and PCWrite are always equal.
- No output may glitch to an undefined value; every output is driven in every state.

Optional Feature:
- Macro: HAZARD_PERF_EN.
- Compiled in:
  - Additional outputs StallCycles[PERF_W-1:0] and FlushCount[PERF_W-1:0], both registered and reset to 0.
  - StallCycles increments each cycle the stall pattern is driven.
  - FlushCount increments each cycle IFFlush=1.
  - Both counters saturate at all-ones (no wrap).
- Compiled out: the outputs and counters are absent, and there is no functional difference on the remaining ports.

Decomposition:
- Shared package hazard_pkg holds:
  - state enum (RUN=0, STALL=1)
  - REG_ZERO constant
  - stall-pattern and idle-pattern 4-bit constants {PCWrite, IFIDWrite, IFFlush, EXFlush}
- Natural sub-module: hazard_match, a combinational srcmatch comparator instanced twice (EX destination and MEM destination).

Test Plan:
- Load-use: IDEX_MemRead=1, IDEX_WriteReg=8, ID_Rs=8, ID_Branch=0 → exactly 1 cycle with PCWrite=0, IFIDWrite=0, EXFlush=1, then idle pattern.
- Branch after load: IDEX_MemRead=1, IDEX_WriteReg=9, ID_Rt=9, ID_UsesRt=1, ID_Branch=1 → 2 stall cycles, Stalled=1 on the second. Then EXMEM_MemRead=1, EXMEM_WriteReg=9 gives a third bubble via rule 3 only if still matching; the bench checks the exact count.
- Branch after ALU op: IDEX_RegWrite=1, IDEX_WriteReg=5, ID_Rs=5, ID_Branch=1, ID_Taken=1 → 1 stall cycle with IFFlush=0. On the next cycle, with the hazard cleared, IFFlush=1 for 1 cycle.
- Register zero: IDEX_MemRead=1, IDEX_WriteReg=0, ID_Rs=0 → no stall, idle pattern.
- Reset mid-STALL: assert Rst asynchronously (between clock edges) on the first STALL cycle → outputs revert to the idle pattern at once, Stalled=0. After release, the first evaluation uses the RUN rules.
- HAZARD_PERF_EN: run the scenarios above → StallCycles=4 (1 + 2 + 1) and FlushCount=1. Preload near all-ones → counters saturate at all-ones rather than wrapping.
